// File: rtl/pattern_gen_if.sv
// Sample-stream bundle between a controller and the pattern generator.
// The controller (master) owns the run/burst controls; the generator (slave)
// returns the registered sample stream and its qualifiers.
interface pattern_gen_if #(
    parameter int W     = 8,
    parameter int LEN_W = 10
);
    logic             nEN;
    logic             START;
    logic [1:0]       MODE;
    logic [W-1:0]     STEP;
    logic [W-1:0]     LIMIT;
    logic [LEN_W-1:0] LEN;
    logic [W-1:0]     Q;
    logic             VALID;
    logic             LAST;
    logic             BUSY;

    modport master (
        output nEN, START, MODE, STEP, LIMIT, LEN,
        input  Q, VALID, LAST, BUSY
    );

    modport slave (
        input  nEN, START, MODE, STEP, LIMIT, LEN,
        output Q, VALID, LAST, BUSY
    );
endinterface

// File: rtl/pattern_gen.sv
// Burst dummy-data generator standing in for the ADC/beamformer front end.
// Emits LEN samples per burst as up-ramp, down-ramp, triangle or Galois LFSR
// noise, qualified by VALID/LAST, with nEN stalls that never drop or repeat data.
module pattern_gen #(
    parameter int W     = 8,
    parameter int LEN_W = 10,
    parameter int SEED  = 1
) (
    input logic         CLK,
    input logic         nCLR,
    pattern_gen_if.slave bus
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [15:0]    TAPS16  = (W == 8)  ? 16'h00B8 :
                                         (W == 12) ? 16'h0E08 : 16'hB400;
    localparam logic [W-1:0]   TAPS    = TAPS16[W-1:0];
    localparam logic [W-1:0]   SEED_W  = W'(SEED);
    localparam logic [W-1:0]   ONE_W   = {{(W-1){1'b0}}, 1'b1};
    localparam logic [W-1:0]   LFSR_INIT = (SEED_W == '0) ? ONE_W : SEED_W;
    localparam logic [LEN_W:0] REM_ONE = {{LEN_W{1'b0}}, 1'b1};
    localparam logic [LEN_W:0] REM_MAX = {1'b1, {LEN_W{1'b0}}};

    // One Galois right-shift step of the noise register.
    function automatic logic [W-1:0] lfsr_step(input logic [W-1:0] v);
        return (v >> 1) ^ (v[0] ? TAPS : '0);
    endfunction

    state_t         state_r;
    logic [1:0]     mode_r;
    logic [W-1:0]   step_r;
    logic [W-1:0]   limit_r;
    logic [LEN_W:0] rem_r;
    logic [W-1:0]   cur_r;
    logic           dir_down_r;
    logic [W-1:0]   lfsr_r;
    logic [W-1:0]   q_r;
    logic           valid_r;
    logic           last_r;

    logic [W:0]     sum_s;
    logic [W-1:0]   diff_s;
    logic [W-1:0]   nxt_cur_s;
    logic           nxt_dir_s;

    assign bus.Q     = q_r;
    assign bus.VALID = valid_r;
    assign bus.LAST  = last_r;
    assign bus.BUSY  = (state_r == RUN);

    // Next ramp/triangle value; comparisons are done one bit wider so a
    // large STEP can never wrap past LIMIT unnoticed.
    always_comb begin
        sum_s     = {1'b0, cur_r} + {1'b0, step_r};
        diff_s    = cur_r - step_r;
        nxt_cur_s = cur_r;
        nxt_dir_s = dir_down_r;
        case (mode_r)
            2'd0: begin
                if (sum_s > {1'b0, limit_r}) nxt_cur_s = '0;
                else                         nxt_cur_s = sum_s[W-1:0];
            end
            2'd1: begin
                if (cur_r < step_r) nxt_cur_s = limit_r;
                else                nxt_cur_s = diff_s;
            end
            2'd2: begin
                if (!dir_down_r) begin
                    if (sum_s >= {1'b0, limit_r}) begin
                        nxt_cur_s = limit_r;
                        nxt_dir_s = 1'b1;
                    end else begin
                        nxt_cur_s = sum_s[W-1:0];
                    end
                end else begin
                    if (cur_r <= step_r) begin
                        nxt_cur_s = '0;
                        nxt_dir_s = 1'b0;
                    end else begin
                        nxt_cur_s = diff_s;
                    end
                end
            end
            default: begin
                nxt_cur_s = cur_r;
                nxt_dir_s = dir_down_r;
            end
        endcase
    end

    // Burst FSM with shadowed controls and registered sample outputs.
    always_ff @(posedge CLK) begin
        if (!nCLR) begin
            state_r    <= IDLE;
            mode_r     <= 2'd0;
            step_r     <= ONE_W;
            limit_r    <= '0;
            rem_r      <= '0;
            cur_r      <= '0;
            dir_down_r <= 1'b0;
            lfsr_r     <= LFSR_INIT;
            q_r        <= '0;
            valid_r    <= 1'b0;
            last_r     <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    valid_r <= 1'b0;
                    last_r  <= 1'b0;
                    if (bus.START) begin
                        state_r    <= RUN;
                        mode_r     <= bus.MODE;
                        step_r     <= (bus.STEP == '0) ? ONE_W : bus.STEP;
                        limit_r    <= bus.LIMIT;
                        rem_r      <= (bus.LEN == '0) ? REM_MAX : {1'b0, bus.LEN};
                        dir_down_r <= 1'b0;
                        case (bus.MODE)
                            2'd0:    cur_r <= '0;
                            2'd1:    cur_r <= bus.LIMIT;
                            2'd2:    cur_r <= '0;
                            default: cur_r <= cur_r;
                        endcase
                    end
                end
                RUN: begin
                    if (!bus.nEN) begin
                        valid_r <= 1'b1;
                        last_r  <= (rem_r == REM_ONE);
                        rem_r   <= rem_r - REM_ONE;
                        if (mode_r == 2'd3) begin
                            q_r    <= lfsr_r;
                            lfsr_r <= lfsr_step(lfsr_r);
                        end else begin
                            q_r        <= cur_r;
                            cur_r      <= nxt_cur_s;
                            dir_down_r <= nxt_dir_s;
                        end
                        if (rem_r == REM_ONE) state_r <= IDLE;
                        else                  state_r <= RUN;
                    end else begin
                        valid_r <= 1'b0;
                        last_r  <= 1'b0;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    valid_r <= 1'b0;
                    last_r  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pattern_gen.sv
// Directed bench for pattern_gen (W=8, LEN_W=4, SEED=1): a table of bursts
// with hand-computed sample sequences plus stall, START-ignore and
// mid-burst reset sequences.
module tb_pattern_gen;

    logic CLK;
    logic nCLR;

    pattern_gen_if #(.W(8), .LEN_W(4)) bus ();

    pattern_gen #(.W(8), .LEN_W(4), .SEED(1)) dut (
        .CLK  (CLK),
        .nCLR (nCLR),
        .bus  (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [1:0] mode;
        logic [7:0] step;
        logic [7:0] limit;
        logic [3:0] len;
        int         n;
        int         off;
    } vec_t;

    vec_t       vecs [8];
    logic [7:0] pool [49];
    int         n_checks;
    int         n_fail;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic run_burst(input int id, input logic [1:0] mode, input logic [7:0] step,
                             input logic [7:0] limit, input logic [3:0] len,
                             input int n, input int off);
        bus.MODE  = mode;
        bus.STEP  = step;
        bus.LIMIT = limit;
        bus.LEN   = len;
        bus.nEN   = 1'b0;
        bus.START = 1'b1;
        tick();
        bus.START = 1'b0;
        chk($sformatf("v%0d_busy_start", id), {31'd0, bus.BUSY}, 32'd1);
        chk($sformatf("v%0d_valid_gap", id), {31'd0, bus.VALID}, 32'd0);
        for (int k = 0; k < n; k++) begin
            tick();
            chk($sformatf("v%0d_valid_%0d", id, k), {31'd0, bus.VALID}, 32'd1);
            chk($sformatf("v%0d_q_%0d", id, k), {24'd0, bus.Q}, {24'd0, pool[off+k]});
            chk($sformatf("v%0d_last_%0d", id, k), {31'd0, bus.LAST}, (k == n-1) ? 32'd1 : 32'd0);
            chk($sformatf("v%0d_busy_%0d", id, k), {31'd0, bus.BUSY}, (k == n-1) ? 32'd0 : 32'd1);
        end
    endtask

    initial begin
        logic [7:0] st_q   [6];
        logic       st_v   [6];
        logic       st_nen [6];
        logic [7:0] ig_q   [4];

        n_checks = 0;
        n_fail   = 0;

        pool = '{8'h01, 8'hB8, 8'h5C,
                 8'h2E, 8'h17, 8'hB3,
                 8'd0, 8'd3, 8'd6, 8'd9, 8'd0, 8'd3,
                 8'd10, 8'd6, 8'd2, 8'd10, 8'd6,
                 8'd0, 8'd2, 8'd4, 8'd5, 8'd3, 8'd1, 8'd0, 8'd2,
                 8'd0, 8'd0, 8'd0,
                 8'd0, 8'd1, 8'd2, 8'd3, 8'd0,
                 8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7,
                 8'd8, 8'd9, 8'd10, 8'd11, 8'd12, 8'd13, 8'd14, 8'd15};

        //          mode   step   limit    len    n   off
        vecs[0] = '{2'd3, 8'd0, 8'd0,   4'd3,  3,  0};   // LFSR from seed
        vecs[1] = '{2'd3, 8'd0, 8'd0,   4'd3,  3,  3};   // LFSR continues
        vecs[2] = '{2'd0, 8'd3, 8'd10,  4'd6,  6,  6};   // up-ramp wrap
        vecs[3] = '{2'd1, 8'd4, 8'd10,  4'd5,  5, 12};   // down-ramp wrap
        vecs[4] = '{2'd2, 8'd2, 8'd5,   4'd8,  8, 17};   // triangle
        vecs[5] = '{2'd0, 8'd5, 8'd0,   4'd3,  3, 25};   // LIMIT=0
        vecs[6] = '{2'd0, 8'd0, 8'd3,   4'd5,  5, 28};   // STEP=0 acts as 1
        vecs[7] = '{2'd0, 8'd1, 8'd255, 4'd0, 16, 33};   // LEN=0 -> 16

        st_nen = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        st_v   = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        st_q   = '{8'd0, 8'd1, 8'd1, 8'd1, 8'd2, 8'd3};
        ig_q   = '{8'd7, 8'd6, 8'd5, 8'd4};

        bus.nEN   = 1'b1;
        bus.START = 1'b0;
        bus.MODE  = 2'd0;
        bus.STEP  = 8'd0;
        bus.LIMIT = 8'd0;
        bus.LEN   = 4'd0;
        nCLR      = 1'b0;
        tick();
        tick();
        chk("rst_q",     {24'd0, bus.Q},     32'd0);
        chk("rst_valid", {31'd0, bus.VALID}, 32'd0);
        chk("rst_last",  {31'd0, bus.LAST},  32'd0);
        chk("rst_busy",  {31'd0, bus.BUSY},  32'd0);
        nCLR = 1'b1;
        tick();

        // Table: bursts run back to back, START on the edge after each LAST.
        for (int i = 0; i < 8; i++) begin
            run_burst(i, vecs[i].mode, vecs[i].step, vecs[i].limit, vecs[i].len,
                      vecs[i].n, vecs[i].off);
        end

        // Stall: nEN high for two cycles after the second sample.
        tick();
        bus.MODE  = 2'd0;
        bus.STEP  = 8'd1;
        bus.LIMIT = 8'd255;
        bus.LEN   = 4'd4;
        bus.START = 1'b1;
        tick();
        bus.START = 1'b0;
        for (int k = 0; k < 6; k++) begin
            bus.nEN = st_nen[k];
            tick();
            chk($sformatf("stall_valid_%0d", k), {31'd0, bus.VALID}, {31'd0, st_v[k]});
            chk($sformatf("stall_q_%0d", k), {24'd0, bus.Q}, {24'd0, st_q[k]});
            chk($sformatf("stall_last_%0d", k), {31'd0, bus.LAST}, (k == 5) ? 32'd1 : 32'd0);
        end
        bus.nEN = 1'b0;

        // START re-pulsed mid-burst and on the LAST edge; inputs changed under the burst.
        tick();
        bus.MODE  = 2'd1;
        bus.STEP  = 8'd1;
        bus.LIMIT = 8'd7;
        bus.LEN   = 4'd4;
        bus.START = 1'b1;
        tick();
        bus.START = 1'b0;
        bus.MODE  = 2'd0;
        bus.LIMIT = 8'd3;
        bus.LEN   = 4'd9;
        for (int k = 0; k < 4; k++) begin
            bus.START = (k == 1 || k == 3);
            tick();
            chk($sformatf("ign_q_%0d", k), {24'd0, bus.Q}, {24'd0, ig_q[k]});
            chk($sformatf("ign_last_%0d", k), {31'd0, bus.LAST}, (k == 3) ? 32'd1 : 32'd0);
        end
        chk("ign_busy_end", {31'd0, bus.BUSY}, 32'd0);
        bus.START = 1'b0;
        tick();
        chk("ign_busy_after", {31'd0, bus.BUSY},  32'd0);
        chk("ign_valid_after", {31'd0, bus.VALID}, 32'd0);

        // Reset during the third sample of an LFSR burst.
        bus.MODE  = 2'd3;
        bus.LEN   = 4'd5;
        bus.START = 1'b1;
        tick();
        bus.START = 1'b0;
        tick();
        tick();
        chk("mid_valid_pre", {31'd0, bus.VALID}, 32'd1);
        nCLR = 1'b0;
        tick();
        nCLR = 1'b1;
        chk("mid_q",     {24'd0, bus.Q},     32'd0);
        chk("mid_valid", {31'd0, bus.VALID}, 32'd0);
        chk("mid_last",  {31'd0, bus.LAST},  32'd0);
        chk("mid_busy",  {31'd0, bus.BUSY},  32'd0);
        tick();
        chk("mid_idle_valid", {31'd0, bus.VALID}, 32'd0);
        run_burst(8, 2'd3, 8'd0, 8'd0, 4'd3, 3, 0);

        tick();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
